// File: rtl/wb_ram_arb_2.sv
// Two-master round-robin Wishbone arbiter in front of one RAM port.
// The grant is held for a whole cyc, and a per-access watchdog answers err when the slave never acks.
module wb_ram_arb_2 #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic                    m0_cyc_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  input  logic                    m1_cyc_i,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic                    s_we_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_stb_o,
  input  logic                    s_ack_i,
  output logic                    s_cyc_o,
  output logic [1:0]              gnt_o
);

  // Handshake: an access is s_cyc_o & s_stb_o, and it completes in the cycle the slave raises s_ack_i.
  // Ack is routed combinationally to the owner. In the err_pend cycle, the strobe is withheld and ack is ignored.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   own_cyc;
  logic   err_pend;

  // The state encoding is the one-hot grant itself.
  assign gnt_o = state;

  always_comb begin
    own_cyc = 1'b0;
    case (state)
      G0:      own_cyc = m0_cyc_i;
      G1:      own_cyc = m1_cyc_i;
      default: own_cyc = 1'b0;
    endcase
  end

  // Re-arbitrate only when idle or when the owner has released cyc. There is no preemption.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    if (state == IDLE || !own_cyc) begin
      if (m0_cyc_i && m1_cyc_i) state_nxt = last ? G0 : G1;
      else if (m0_cyc_i)        state_nxt = G0;
      else if (m1_cyc_i)        state_nxt = G1;
      else                      state_nxt = IDLE;
      if (state_nxt == G0)      last_nxt = 1'b0;
      else if (state_nxt == G1) last_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      G0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & m0_cyc_i & ~err_pend;
        m0_ack_o = s_ack_i & ~err_pend;
        m0_err_o = err_pend;
      end
      G1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & m1_cyc_i & ~err_pend;
        m1_ack_o = s_ack_i & ~err_pend;
        m1_err_o = err_pend;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int WW = $clog2(TIMEOUT + 1);
      localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
      logic [WW-1:0] wdog;

      // Counts stalled strobe cycles. The TIMEOUT-th stalled cycle raises a one-cycle err_pend.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wdog     <= '0;
          err_pend <= 1'b0;
        end else begin
          err_pend <= 1'b0;
          if (!s_stb_o || s_ack_i || state_nxt != state) begin
            wdog <= '0;
          end else if (wdog == WDOG_LAST) begin
            wdog     <= '0;
            err_pend <= 1'b1;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
      end
    end else begin : g_no_wdog
      assign err_pend = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_ram_arb_2.sv
// Directed bench for wb_ram_arb_2. A behavioural arbiter/RAM model is checked every cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_wb_ram_arb_2;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic [1:0]  cyc, stb, we;
  logic [15:0] adr [2];
  logic [31:0] wdat [2];
  logic [3:0]  sel [2];
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [15:0] s_adr_o;
  logic [31:0] s_dat_i, s_dat_o;
  logic        s_we_o, s_stb_o, s_ack_i, s_cyc_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  gnt_o;
  logic        ack_en;

  int n_chk = 0;
  int n_pass = 0;
  bit run_chk = 0;
  bit log_en = 0;
  bit burst_mon = 0;
  int burst_m1_acks = 0;
  logic [1:0] gnt_log [$];

  wb_ram_arb_2 #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .SELECT_WIDTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_rdat), .m0_we_i(we[0]),
    .m0_sel_i(sel[0]), .m0_stb_i(stb[0]), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_cyc_i(cyc[0]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_rdat), .m1_we_i(we[1]),
    .m1_sel_i(sel[1]), .m1_stb_i(stb[1]), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_cyc_i(cyc[1]),
    .s_adr_o(s_adr_o), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_cyc_o(s_cyc_o), .gnt_o(gnt_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM slave (zero-wait, combinational ack) ----------------
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  assign s_ack_i = s_stb_o & ack_en;
  assign s_dat_i = mem[s_adr_o[9:2]];
  always @(posedge clk)
    if (s_stb_o && s_ack_i && s_we_o)
      for (int b = 0; b < 4; b++)
        if (s_sel_o[b]) mem[s_adr_o[9:2]][8*b +: 8] <= s_dat_o[8*b +: 8];

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int   owner;   // -1 idle, else master index
    logic last;
    int   stall;   // consecutive unacked strobe cycles of the current owner
    logic errp;
  } mstate_t;

  localparam mstate_t M_RST = '{owner: -1, last: 1'b1, stall: 0, errp: 1'b0};
  mstate_t m = M_RST;
  logic [31:0] exp_mem [256];
  initial for (int i = 0; i < 256; i++) exp_mem[i] = '0;

  function automatic mstate_t step(mstate_t s, logic [1:0] c, logic [1:0] sb, logic ae);
    mstate_t n;
    bit busy;
    n = s;
    busy = (s.owner >= 0) && c[s.owner[0]] && sb[s.owner[0]] && !s.errp;
    if (s.owner < 0 || !c[s.owner[0]]) begin
      if (c == 2'b11)  n.owner = s.last ? 0 : 1;
      else if (c[0])   n.owner = 0;
      else if (c[1])   n.owner = 1;
      else             n.owner = -1;
      if (n.owner >= 0) n.last = (n.owner == 1);
    end
    n.errp = 1'b0;
    if (busy && !ae) begin
      if (s.stall + 1 >= TIMEOUT) begin
        n.errp  = 1'b1;
        n.stall = 0;
      end else begin
        n.stall = s.stall + 1;
      end
    end else begin
      n.stall = 0;
    end
    if (n.owner != s.owner) n.stall = 0;
    return n;
  endfunction

  logic       own_v, own_i, e_cyc, e_stb;
  logic [1:0] e_gnt, e_ack, e_err;
  assign own_v = (m.owner >= 0);
  assign own_i = m.owner[0];
  assign e_gnt = own_v ? (own_i ? 2'b10 : 2'b01) : 2'b00;
  assign e_cyc = own_v && cyc[own_i];
  assign e_stb = e_cyc && stb[own_i] && !m.errp;
  assign e_ack = (e_stb && ack_en) ? e_gnt : 2'b00;
  assign e_err = m.errp ? e_gnt : 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) m <= M_RST;
    else     m <= step(m, cyc, stb, ack_en);
  end

  always @(posedge clk)
    if (!rst && e_stb && ack_en && we[own_i])
      for (int b = 0; b < 4; b++)
        if (sel[own_i][b]) exp_mem[adr[own_i][9:2]][8*b +: 8] <= wdat[own_i][8*b +: 8];

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("gnt", {30'd0, gnt_o}, {30'd0, e_gnt});
      chk("s_cyc", {31'd0, s_cyc_o}, {31'd0, e_cyc});
      chk("s_stb", {31'd0, s_stb_o}, {31'd0, e_stb});
      chk("ack", {30'd0, m1_ack, m0_ack}, {30'd0, e_ack});
      chk("err", {30'd0, m1_err, m0_err}, {30'd0, e_err});
      if (e_stb) begin
        chk("s_adr", {16'd0, s_adr_o}, {16'd0, adr[own_i]});
        chk("s_we", {31'd0, s_we_o}, {31'd0, we[own_i]});
        chk("s_sel", {28'd0, s_sel_o}, {28'd0, sel[own_i]});
        if (we[own_i]) chk("s_dat", s_dat_o, wdat[own_i]);
        else           chk("rdat", own_i ? m1_rdat : m0_rdat, exp_mem[adr[own_i][9:2]]);
      end
      if (log_en && (m0_ack || m1_ack)) gnt_log.push_back(gnt_o);
      if (burst_mon && cyc[0] && m1_ack) burst_m1_acks <= burst_m1_acks + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cyc = '0; stb = '0; we = '0;
    for (int i = 0; i < 2; i++) begin
      adr[i] = '0; wdat[i] = '0; sel[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
    chk("rst_s_stb_cyc", {30'd0, s_stb_o, s_cyc_o}, 32'd0);
    chk("rst_ack_err", {28'd0, m1_ack, m0_ack, m1_err, m0_err}, 32'd0);
    rst = 1'b0;
    run_chk = 1'b1;
  endtask

  task automatic access(input int mi, input logic [15:0] a, input logic [31:0] d, input logic w,
                        input logic [3:0] s, input bit keep, output logic [31:0] rd);
    bit done;
    done = 0;
    rd = '0;
    cyc[mi] = 1'b1; stb[mi] = 1'b1; adr[mi] = a; wdat[mi] = d; we[mi] = w; sel[mi] = s;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (mi == 0 ? m0_ack : m1_ack) begin
        done = 1;
        rd = (mi == 0) ? m0_rdat : m1_rdat;
      end
    end
    if (!done) chk("access_bound", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    stb[mi] = 1'b0;
    if (!keep) cyc[mi] = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] rd0, rd1;
    int cnt;
    bit got;
    rst = 1'b1;
    ack_en = 1'b1;
    clear_inputs();
    do_reset();

    // m0 single write, m1 idle
    tick();
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 16'h0010; wdat[0] = 32'h11223344; sel[0] = 4'hF;
    @(negedge clk);
    chk("w_gnt_before", {30'd0, gnt_o}, 32'd0);
    @(negedge clk);
    chk("w_gnt", {30'd0, gnt_o}, 32'd1);
    chk("w_ack", {31'd0, m0_ack}, 32'd1);
    tick();
    cyc[0] = 0; stb[0] = 0; we[0] = 0;
    tick();
    chk("w_ram_word", mem[4], 32'h11223344);

    // simultaneous request after reset: m0 first, then m1 with no gap
    do_reset();
    tick();
    cyc = 2'b11; stb = 2'b11; we = 2'b00;
    adr[0] = 16'h0010; adr[1] = 16'h0010; sel[0] = 4'hF; sel[1] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("tie_gnt_m0", {30'd0, gnt_o}, 32'd1);
    chk("tie_rdat_m0", m0_rdat, 32'h11223344);
    tick();
    cyc[0] = 0; stb[0] = 0;
    @(negedge clk);
    chk("drop_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    @(negedge clk);
    chk("handover_gnt_m1", {30'd0, gnt_o}, 32'd2);
    chk("handover_ack_m1", {31'd0, m1_ack}, 32'd1);
    tick();
    cyc[1] = 0; stb[1] = 0;
    tick();

    // continuous requests from both, single accesses: grants alternate
    log_en = 1;
    fork
      for (int i = 0; i < 2; i++) begin
        access(0, 16'h0040 + 16'(8 * i), 32'hA0A0_0000 + i, 1'b1, 4'hF, 1'b0, rd0);
        tick();
      end
      for (int i = 0; i < 2; i++) begin
        access(1, 16'h0044 + 16'(8 * i), 32'hB1B1_0000 + i, 1'b1, 4'hF, 1'b0, rd1);
        tick();
      end
    join
    log_en = 0;
    chk("rr_count", gnt_log.size(), 32'd4);
    if (gnt_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("rr_order", {30'd0, gnt_log[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);

    // m0 holds cyc over a 4-beat burst while m1 waits
    burst_mon = 1;
    fork
      begin
        access(0, 16'h0010, 32'hAAAA_BBBB, 1'b1, 4'h3, 1'b1, rd0);
        for (int i = 1; i < 4; i++)
          access(0, 16'h0080 + 16'(4 * i), 32'hC0DE_0000 + i, 1'b1, 4'hF, i < 3, rd0);
      end
      begin
        tick();
        access(1, 16'h0010, 32'd0, 1'b0, 4'hF, 1'b0, rd1);
      end
    join
    burst_mon = 0;
    chk("burst_m1_no_ack", burst_m1_acks, 32'd0);
    chk("burst_m1_read", rd1, 32'h1122_BBBB);
    tick();

    // watchdog: slave never acks
    ack_en = 0;
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 16'h0020; sel[0] = 4'hF;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (s_stb_o) got = 1;
    end
    chk("wdog_stb_rise", {31'd0, got}, 32'd1);
    cnt = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      cnt++;
      if (m0_err) got = 1;
    end
    chk("wdog_latency", cnt, 32'd16);
    chk("wdog_err_stb", {31'd0, s_stb_o}, 32'd0);
    chk("wdog_err_gnt", {30'd0, gnt_o}, 32'd1);
    tick();
    cyc[0] = 0; stb[0] = 0;
    ack_en = 1;
    tick();

    // reset in the middle of an m1 write
    ack_en = 0;
    cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 16'h0030; wdat[1] = 32'hDEAD_BEEF; sel[1] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("mid_gnt_m1", {30'd0, gnt_o}, 32'd2);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_gnt", {30'd0, gnt_o}, 32'd0);
    chk("mid_rst_s", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    ack_en = 1;
    tick();
    cyc = 2'b11; stb = 2'b11; we = 2'b00; adr[0] = 16'h0010; adr[1] = 16'h0010;
    sel[0] = 4'hF; sel[1] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_tie_m0", {30'd0, gnt_o}, 32'd1);
    tick();
    clear_inputs();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit actual=expired required=finish");
    $fatal(1);
  end

endmodule
